// File: rtl/integrate_dump.sv
// -----------------------------------------------------------------------------
// integrate_dump
//
// Integrate-and-dump decimator. It sums each window of SPS accepted input
// samples, arithmetically shifts the sum right by SHIFT, saturates the result
// to DATA_W bits and emits it as one output word per window.
//
// Both stream sides share one clock. Backpressure is applied upstream only
// when a window is about to close and the single output slot is still
// occupied, so input samples are never dropped.
//
// Ports:
//   s_axis_aclk    in   1       sole clock
//   rst            in   1       synchronous reset, active-high
//   s_axis_tdata   in   DATA_W  input sample, signed
//   s_axis_tvalid  in   1       input sample valid
//   s_axis_tready  out  1       input accept (combinational)
//   align          in   1       restart the window with this sample
//                               (only acts together with an input accept)
//   m_axis_tdata   out  DATA_W  decimated sample, signed (registered)
//   m_axis_tvalid  out  1       output valid (registered)
//   m_axis_tready  in   1       downstream accept
// -----------------------------------------------------------------------------
module integrate_dump #(
  parameter int DATA_W = 16,
  parameter int SPS    = 8,   // samples per window, must be >= 2
  parameter int SHIFT  = 3    // arithmetic right shift of the window sum
) (
  input  logic              s_axis_aclk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              align,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready
);

  localparam int CNT_W = (SPS > 1) ? $clog2(SPS) : 1;
  // Wide enough to hold SPS full-scale samples of either sign.
  localparam int ACC_W = DATA_W + CNT_W;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Saturation bounds expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(CNT_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(CNT_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic        [CNT_W-1:0]  cnt_q, cnt_d;
  logic        [DATA_W-1:0] m_data_q, m_data_d;
  logic                     m_valid_q, m_valid_d;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic                    in_fire;
  logic                    out_fire;
  logic                    win_last;
  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] shifted;
  logic        [DATA_W-1:0] sat_val;

  assign win_last = (cnt_q == CNT_LAST);

  // Only the window-closing sample can be stalled: it needs the output slot
  // to be empty or emptying in this very cycle. Reset forces ready high so
  // the upstream sees a clean accept while the state is being cleared.
  assign s_axis_tready = rst || !win_last || !m_valid_q || m_axis_tready;

  assign in_fire  = s_axis_tvalid && s_axis_tready;
  assign out_fire = m_valid_q && m_axis_tready;

  assign x_ext   = {{CNT_W{s_axis_tdata[DATA_W-1]}}, s_axis_tdata};
  assign sum     = acc_q + x_ext;
  // >>> on a signed operand floors toward minus infinity.
  assign shifted = sum >>> SHIFT;

  always_comb begin
    if (shifted > SAT_MAX) begin
      sat_val = SAT_MAX[DATA_W-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_val = SAT_MIN[DATA_W-1:0];
    end else begin
      sat_val = shifted[DATA_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block is given a default first so that no
    // path leaves a value unassigned, which would infer a latch.
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;

    // Slot drains first; a window close below may refill it in the same
    // cycle, giving back-to-back output words.
    if (out_fire) begin
      m_valid_d = 1'b0;
    end

    if (in_fire) begin
      if (align) begin
        // Restart wins over completion: the partial window is discarded.
        acc_d = x_ext;
        cnt_d = CNT_ONE;
      end else if (win_last) begin
        acc_d     = '0;
        cnt_d     = '0;
        m_data_d  = sat_val;
        m_valid_d = 1'b1;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge s_axis_aclk) begin
    // NOTE: state is updated with non-blocking assignments so that every
    // register samples the pre-edge values, independent of statement order.
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign m_axis_tdata  = m_data_q;
  assign m_axis_tvalid = m_valid_q;

endmodule

// File: tb/tb_integrate_dump.sv
// -----------------------------------------------------------------------------
// tb_integrate_dump
//
// Two instances share all inputs: the default one (SHIFT=3) and a SHIFT=0
// one that exercises saturation. Both have identical handshake timing, so a
// single window model predicts ready/valid for both and a data value per
// instance. Every cycle the bench drives inputs after the falling edge,
// compares all outputs against the model, then advances the model across the
// rising edge using the model's own idea of ready.
// -----------------------------------------------------------------------------
module tb_integrate_dump;

  localparam int DATA_W = 16;
  localparam int SPS    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] s_tdata;
  logic              s_tvalid;
  logic              align;
  logic              m_tready;

  logic              s_tready3, s_tready0;
  logic [DATA_W-1:0] m_tdata3,  m_tdata0;
  logic              m_tvalid3, m_tvalid0;

  always #5 clk = ~clk;

  integrate_dump #(.DATA_W(DATA_W), .SPS(SPS), .SHIFT(3)) dut (
    .s_axis_aclk   (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready3),
    .align         (align),
    .m_axis_tdata  (m_tdata3),
    .m_axis_tvalid (m_tvalid3),
    .m_axis_tready (m_tready)
  );

  integrate_dump #(.DATA_W(DATA_W), .SPS(SPS), .SHIFT(0)) dut_s0 (
    .s_axis_aclk   (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready0),
    .align         (align),
    .m_axis_tdata  (m_tdata0),
    .m_axis_tvalid (m_tvalid0),
    .m_axis_tready (m_tready)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the window is a list of accepted samples; the output is
  // one slot holding the value for each instance.
  // ---------------------------------------------------------------------------
  int     win[$];
  bit     mv;
  longint md3, md0;
  int     exp_outs, got_outs3, got_outs0;

  function automatic longint floor_shift(input longint s, input int k);
    longint d, m;
    d = longint'(1) << k;
    m = ((s % d) + d) % d;
    return (s - m) / d;
  endfunction

  function automatic longint sat16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // One clock cycle with the given inputs.
  task automatic cycle(input bit v, input int x, input bit al, input bit mr,
                       input bit r = 1'b0);
    bit     exp_ready, acc, ofire;
    longint s;
    rst      = r;
    s_tvalid = v;
    s_tdata  = DATA_W'(x);
    align    = al;
    m_tready = mr;
    #1;
    exp_ready = r || (win.size() != SPS - 1) || !mv || mr;
    check("ready",   s_tready3, exp_ready);
    check("ready_s0", s_tready0, exp_ready);
    check("valid",   m_tvalid3, mv);
    check("valid_s0", m_tvalid0, mv);
    check("data",    longint'($signed(m_tdata3)), md3);
    check("data_s0", longint'($signed(m_tdata0)), md0);
    @(posedge clk);
    if (!r) begin
      if (m_tvalid3 && m_tready) got_outs3++;
      if (m_tvalid0 && m_tready) got_outs0++;
    end
    acc   = v && exp_ready;
    ofire = mv && mr;
    if (r) begin
      win.delete();
      mv  = 1'b0;
      md3 = 0;
      md0 = 0;
    end else begin
      if (ofire) mv = 1'b0;
      if (acc) begin
        if (al) begin
          win.delete();
          win.push_back(int'($signed(DATA_W'(x))));
        end else begin
          win.push_back(int'($signed(DATA_W'(x))));
          if (win.size() == SPS) begin
            s = 0;
            foreach (win[i]) s += win[i];
            md3 = sat16(floor_shift(s, 3));
            md0 = sat16(s);
            mv  = 1'b1;
            exp_outs++;
            win.delete();
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input int x, input int n = 1, input bit al = 1'b0);
    for (int i = 0; i < n; i++) cycle(1'b1, x, al, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 1'b1);
  endtask

  function automatic int rand_sample();
    case ($urandom_range(3))
      0:       return $urandom_range(65535) - 32768;
      1:       return $urandom_range(200) - 100;
      2:       return 32767;
      default: return -32768;
    endcase
  endfunction

  initial begin
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; align = 1'b0; m_tready = 1'b1;
    win.delete(); mv = 1'b0; md3 = 0; md0 = 0;
    exp_outs = 0; got_outs3 = 0; got_outs0 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state, with a sample offered during reset.
    cycle(1'b1, 123, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b1);

    // Basic windows and floor rounding.
    send(100, 8);
    idle(2);
    for (int i = 0; i < 8; i++) send(i);
    send(-3, 8);
    send(0, 7); send(-1);
    idle(2);

    // Saturation on the SHIFT=0 instance, zero sum.
    send(32767, 8);
    send(-32768, 8);
    send(1000, 4); send(-1000, 4);
    idle(2);

    // Backpressure: 16 samples of 5 with downstream stalled.
    for (int i = 0; i < 17; i++) cycle(1'b1, 5, 1'b0, 1'b0);
    cycle(1'b1, 5, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1);
    idle(1);

    // Align restarts the window.
    send(50, 3); send(10, 1, 1'b1); send(10, 7);
    idle(2);

    // Align on the would-be closing sample.
    send(20, 7); send(20, 1, 1'b1); send(20, 7);
    idle(2);

    // Reset mid-window.
    send(77, 5);
    cycle(1'b1, 77, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 77, 1'b0, 1'b1, 1'b1);
    send(20, 8);
    idle(2);

    // Gapped input with align sampled while not accepting.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 999, 1'b1, 1'b1);
      send(i * 7 - 40);
    end
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(9) < 7, rand_sample(), $urandom_range(23) == 0,
            $urandom_range(9) < 6, $urandom_range(299) == 0);
    end

    // Drain and compare output counts.
    idle(4);
    check("outs", got_outs3, exp_outs);
    check("outs_s0", got_outs0, exp_outs);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
